// File: rtl/iic_pkg.sv
// Shared definitions for the key-to-I2C command front end:
// bus widths, default debounce length and the FSM state encoding.
package iic_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  // 20 ms of stable level at a 50 MHz system clock.
  localparam int DEBOUNCE_CNT_DEF = 1_000_000;

  // Command FSM encoding, kept as plain constants so legacy tools and
  // waveform viewers see stable numeric values.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_REQ  = 3'd1;
  localparam logic [2:0] ST_WR_WAIT = 3'd2;
  localparam logic [2:0] ST_RD_REQ  = 3'd3;
  localparam logic [2:0] ST_RD_WAIT = 3'd4;

endpackage

// File: rtl/iic_key_cmd_if.sv
// Command handshake between the key front end (master) and the I2C
// EEPROM controller (slave): request strobes, address/data out,
// completion pulse, read data and NACK status back.
interface iic_key_cmd_if;
  import iic_pkg::*;

  logic              iic_wr_req;
  logic              iic_rd_req;
  logic [ADDR_W-1:0] iic_addr;
  logic [DATA_W-1:0] iic_wdata;
  logic              iic_done;
  logic [DATA_W-1:0] iic_rdata;
  logic              iic_ack_err;

  modport master (
    output iic_wr_req, iic_rd_req, iic_addr, iic_wdata,
    input  iic_done, iic_rdata, iic_ack_err
  );

  modport slave (
    input  iic_wr_req, iic_rd_req, iic_addr, iic_wdata,
    output iic_done, iic_rdata, iic_ack_err
  );

endinterface

// File: rtl/key_debounce.sv
// One push-button channel: 2-FF synchroniser, stability counter and a
// single-cycle pulse on each accepted press (active-low key, 1->0).
// Release (0->1) is debounced the same way but produces no pulse.
module key_debounce
  import iic_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key,
  output logic o_press
);

  localparam int              CNT_W   = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CNT - 1);

  logic [1:0]       r_sync;
  logic             r_level;
  logic             r_level_d;
  logic [CNT_W-1:0] r_cnt;
  logic             w_sync;

  assign w_sync = r_sync[1];

  // Bring the raw pin into the clock domain; idle level of the key is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
    end else begin
      // NOTE: clocked state always uses <= so every register samples the
      // pre-edge values; a blocking = here would collapse the two stages.
      r_sync <= {r_sync[0], w_sync == w_sync ? i_key : i_key};
    end
  end

  // Count while the synchronised level disagrees with the accepted one;
  // any return to the accepted level restarts the count, so short
  // glitches never reach the end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b1;
    end else if (w_sync == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt   <= '0;
      r_level <= w_sync;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Delayed copy of the accepted level for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level_d <= 1'b1;
    end else begin
      r_level_d <= r_level;
    end
  end

  assign o_press = r_level_d & ~r_level;

endmodule

// File: rtl/iic_key_cmd.sv
// Key front end for the I2C EEPROM controller inside iic_top.
// key_in1 press -> one byte write of an incrementing counter,
// key_in2 press -> one byte read, result shown on led.
// Optional feature macro: IIC_CMD_TIMEOUT_EN adds a completion timeout
// in the wait states (TIMEOUT_CNT cycles); without it the FSM waits
// for iic_done indefinitely.
module iic_key_cmd
  import iic_pkg::*;
#(
  parameter int                DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
  parameter logic [ADDR_W-1:0] WORD_ADDR    = 8'h00,
  parameter logic [DATA_W-1:0] DATA_INIT    = 8'hA5,
  parameter int                TIMEOUT_CNT  = 2_000_000
) (
  input  logic              s_clk,
  input  logic              s_rst_n,
  input  logic              key_in1,
  input  logic              key_in2,
  iic_key_cmd_if.master     iic,
  output logic [DATA_W-1:0] led,
  output logic              busy,
  output logic              err
);

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_led;
  logic              r_err;
  logic              w_press1;
  logic              w_press2;
  logic              w_wait;
  logic              w_tmo;
  logic              w_wr_done;
  logic              w_rd_done;

  key_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_key_wr (
    .clk     (s_clk),
    .rst_n   (s_rst_n),
    .i_key   (key_in1),
    .o_press (w_press1)
  );

  key_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_key_rd (
    .clk     (s_clk),
    .rst_n   (s_rst_n),
    .i_key   (key_in2),
    .o_press (w_press2)
  );

  assign w_wait    = (r_state == ST_WR_WAIT) || (r_state == ST_RD_WAIT);
  // iic_done only counts while a transaction is being waited on.
  assign w_wr_done = (r_state == ST_WR_WAIT) && iic.iic_done;
  assign w_rd_done = (r_state == ST_RD_WAIT) && iic.iic_done;

`ifdef IIC_CMD_TIMEOUT_EN
  localparam int               TMO_W   = (TIMEOUT_CNT > 1) ? $clog2(TIMEOUT_CNT) : 1;
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CNT - 1);

  logic [TMO_W-1:0] r_tmo_cnt;

  // Wait-state watchdog; restarts on every state change so each
  // transaction gets the full window.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_tmo_cnt <= '0;
    end else if (!w_wait || (r_state != w_state_nxt)) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign w_tmo = w_wait && !iic.iic_done && (r_tmo_cnt == TMO_MAX);
`else
  assign w_tmo = 1'b0;

  if (TIMEOUT_CNT < 2) begin : g_bad_timeout
    $error("iic_key_cmd: TIMEOUT_CNT must be at least 2");
  end
`endif

  // Next-state decode; presses outside IDLE are simply not looked at.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // the signal unassigned, which would infer a latch.
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_press1)      w_state_nxt = ST_WR_REQ;
        else if (w_press2) w_state_nxt = ST_RD_REQ;
      end
      ST_WR_REQ:  w_state_nxt = ST_WR_WAIT;
      ST_WR_WAIT: if (iic.iic_done || w_tmo) w_state_nxt = ST_IDLE;
      ST_RD_REQ:  w_state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: if (iic.iic_done || w_tmo) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Completion handling: write counter advances and err clears only on
  // an acknowledged transfer; NACK or timeout sets err and leaves data.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_wdata <= DATA_INIT;
      r_led   <= '0;
      r_err   <= 1'b0;
    end else if (w_wr_done) begin
      if (iic.iic_ack_err) begin
        r_err <= 1'b1;
      end else begin
        r_err   <= 1'b0;
        r_wdata <= r_wdata + 1'b1;
      end
    end else if (w_rd_done) begin
      if (iic.iic_ack_err) begin
        r_err <= 1'b1;
      end else begin
        r_err <= 1'b0;
        r_led <= iic.iic_rdata;
      end
    end else if (w_tmo) begin
      r_err <= 1'b1;
    end
  end

  assign iic.iic_wr_req = (r_state == ST_WR_REQ);
  assign iic.iic_rd_req = (r_state == ST_RD_REQ);
  assign iic.iic_addr   = WORD_ADDR;
  assign iic.iic_wdata  = r_wdata;
  assign led            = r_led;
  assign busy           = (r_state != ST_IDLE);
  assign err            = r_err;

endmodule

// File: tb/tb_iic_key_cmd.sv
// Bench for iic_key_cmd with short debounce/timeout windows. Expected
// requests go into a scoreboard queue as keys are pressed; a monitor
// pops and compares whenever the DUT raises a request strobe.
module tb_iic_key_cmd;
  import iic_pkg::*;

  localparam int DEB = 16;
  localparam int TMO = 64;

  typedef struct {
    bit         is_wr;
    logic [7:0] wdata;
  } exp_t;

  logic       s_clk   = 1'b0;
  logic       s_rst_n = 1'b0;
  logic       key_in1 = 1'b1;
  logic       key_in2 = 1'b1;
  logic [7:0] led;
  logic       busy;
  logic       err;

  iic_key_cmd_if iic ();

  iic_key_cmd #(
    .DEBOUNCE_CNT (DEB),
    .WORD_ADDR    (8'h00),
    .DATA_INIT    (8'hA5),
    .TIMEOUT_CNT  (TMO)
  ) dut (
    .s_clk   (s_clk),
    .s_rst_n (s_rst_n),
    .key_in1 (key_in1),
    .key_in2 (key_in2),
    .iic     (iic),
    .led     (led),
    .busy    (busy),
    .err     (err)
  );

  always #5 s_clk = ~s_clk;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_req    = 0;
  logic [7:0] exp_wdata = 8'hA5;
  logic [7:0] exp_led   = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Request monitor: every strobe cycle must match the head of the queue.
  always @(negedge s_clk) begin
    if (iic.iic_wr_req || iic.iic_rd_req) begin
      n_req++;
      check("req_exclusive", {31'd0, iic.iic_wr_req & iic.iic_rd_req}, 32'd0);
      check("req_expected", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("req_kind", {31'd0, iic.iic_wr_req}, {31'd0, mon_e.is_wr});
        check("req_addr", {24'd0, iic.iic_addr}, 32'h00);
        if (mon_e.is_wr) check("req_wdata", {24'd0, iic.iic_wdata}, {24'd0, mon_e.wdata});
      end
    end
  end

  task automatic press(input bit k1, input bit k2, input int n);
    @(posedge s_clk); #1;
    if (k1) key_in1 = 1'b0;
    if (k2) key_in2 = 1'b0;
    repeat (n) @(posedge s_clk);
    #1;
    key_in1 = 1'b1;
    key_in2 = 1'b1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge s_clk);
    #1;
  endtask

  task automatic wait_req(input int target);
    for (int i = 0; i < 200 && n_req < target; i++) begin
      @(negedge s_clk); #1;
    end
    check("req_seen", {31'd0, n_req >= target}, 32'd1);
  endtask

  // Drive one iic_done pulse, then land on the negedge of the cycle after.
  task automatic complete(input bit nack, input logic [7:0] rd);
    @(posedge s_clk); #1;
    iic.iic_done    = 1'b1;
    iic.iic_ack_err = nack;
    iic.iic_rdata   = rd;
    @(posedge s_clk); #1;
    iic.iic_done    = 1'b0;
    iic.iic_ack_err = 1'b0;
    iic.iic_rdata   = 8'h00;
    @(negedge s_clk);
    if (!nack && rd === 8'hxx) exp_led = exp_led;
  endtask

  task automatic issue(input bit is_wr);
    int target;
    target = n_req + 1;
    exp_q.push_back('{is_wr, exp_wdata});
    press(is_wr, !is_wr, 20);
    wait_req(target);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int saved;
    iic.iic_done    = 1'b0;
    iic.iic_ack_err = 1'b0;
    iic.iic_rdata   = 8'h00;

    // Reset state
    tick(5);
    s_rst_n = 1'b1;
    tick(3);
    check("rst_led",   {24'd0, led}, 32'h00);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_err",   {31'd0, err}, 32'd0);
    check("rst_wdata", {24'd0, iic.iic_wdata}, 32'hA5);
    check("rst_addr",  {24'd0, iic.iic_addr}, 32'h00);

    // Write path
    issue(1'b1);
    tick(30);
    check("wr_busy_wait", {31'd0, busy}, 32'd1);
    complete(1'b0, 8'h00);
    exp_wdata = exp_wdata + 8'd1;
    check("wr_wdata_inc", {24'd0, iic.iic_wdata}, {24'd0, exp_wdata});
    check("wr_busy_done", {31'd0, busy}, 32'd0);
    tick(30);

    // Read path
    issue(1'b0);
    tick(5);
    complete(1'b0, 8'h5C);
    exp_led = 8'h5C;
    check("rd_led",   {24'd0, led}, {24'd0, exp_led});
    check("rd_err",   {31'd0, err}, 32'd0);
    check("rd_busy",  {31'd0, busy}, 32'd0);
    check("rd_wdata", {24'd0, iic.iic_wdata}, {24'd0, exp_wdata});
    tick(30);

    // Short glitch on key_in1
    saved = n_req;
    press(1'b1, 1'b0, 10);
    tick(40);
    check("glitch_no_req", n_req, saved);
    check("glitch_busy", {31'd0, busy}, 32'd0);

    // Both keys in the same cycle: write wins, read dropped
    saved = n_req;
    exp_q.push_back('{1'b1, exp_wdata});
    press(1'b1, 1'b1, 20);
    wait_req(saved + 1);
    tick(40);
    check("both_one_req", n_req, saved + 1);
    complete(1'b0, 8'h00);
    exp_wdata = exp_wdata + 8'd1;
    check("both_wdata", {24'd0, iic.iic_wdata}, {24'd0, exp_wdata});
    tick(40);

    // Read key while busy is discarded
    saved = n_req;
    issue(1'b1);
    press(1'b0, 1'b1, 20);
    tick(40);
    complete(1'b0, 8'h00);
    exp_wdata = exp_wdata + 8'd1;
    tick(40);
    check("busy_press_dropped", n_req, saved + 1);
    check("busy_wdata", {24'd0, iic.iic_wdata}, {24'd0, exp_wdata});

    // NACK on a read, then a good write clears err
    issue(1'b0);
    complete(1'b1, 8'h33);
    check("nack_err", {31'd0, err}, 32'd1);
    check("nack_led", {24'd0, led}, {24'd0, exp_led});
    tick(30);
    issue(1'b1);
    check("nack_err_held", {31'd0, err}, 32'd1);
    complete(1'b0, 8'h00);
    exp_wdata = exp_wdata + 8'd1;
    check("recover_err",   {31'd0, err}, 32'd0);
    check("recover_wdata", {24'd0, iic.iic_wdata}, {24'd0, exp_wdata});
    tick(30);

`ifdef IIC_CMD_TIMEOUT_EN
    // Withheld iic_done
    issue(1'b1);
    tick(30);
    check("tmo_still_busy", {31'd0, busy}, 32'd1);
    tick(40);
    check("tmo_busy",  {31'd0, busy}, 32'd0);
    check("tmo_err",   {31'd0, err}, 32'd1);
    check("tmo_wdata", {24'd0, iic.iic_wdata}, {24'd0, exp_wdata});
    check("tmo_led",   {24'd0, led}, {24'd0, exp_led});
    tick(30);
`endif

    // Reset in WR_WAIT
    issue(1'b1);
    tick(5);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    @(posedge s_clk); #1;
    s_rst_n = 1'b0;
    #2;
    check("arst_busy",   {31'd0, busy}, 32'd0);
    check("arst_err",    {31'd0, err}, 32'd0);
    check("arst_led",    {24'd0, led}, 32'h00);
    check("arst_wdata",  {24'd0, iic.iic_wdata}, 32'hA5);
    check("arst_wr_req", {31'd0, iic.iic_wr_req}, 32'd0);
    check("arst_rd_req", {31'd0, iic.iic_rd_req}, 32'd0);
    exp_wdata = 8'hA5;
    exp_led   = 8'h00;
    saved = n_req;
    tick(3);
    s_rst_n = 1'b1;
    tick(40);
    check("no_reissue", n_req, saved);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
